// File: rtl/ft_rx_pkg.sv
// Shared constants and state encoding for the FT601 245-synchronous FIFO receive path.
package ft_rx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OE   = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;
    localparam logic [1:0] ST_TURN = 2'd3;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_BE_W   = 4;

    // Free slots required before starting a burst: one for the first word, one of margin.
    localparam int unsigned MIN_FREE = 2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_OE   = ST_OE,
        S_READ = ST_READ,
        S_TURN = ST_TURN
    } state_t;

endpackage

// File: rtl/rx_fifo.sv
// Single-clock show-ahead FIFO; head word is visible whenever not_empty is high.
module rx_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   not_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty;
    // A push into a full buffer is only legal when the same edge pops.
    assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ft_rx_reader.sv
// FT601 master-side reader: runs the OE/READ/TURN handshake and buffers words as a stream.
module ft_rx_reader
    import ft_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned BE_W       = DEF_BE_W,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rxf_n_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [BE_W-1:0]   be_in,
    output logic              oe_n_out,
    output logic              rd_n_out,
    output logic              bus_rd_out,
    output logic [DATA_W-1:0] data_out,
    output logic [BE_W-1:0]   be_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CNT_W-1:0]  word_cnt_out
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FW = DATA_W + BE_W;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [CW-1:0] free_after;
    logic          cap;
    logic          pop;
    logic [FW-1:0] head;

    assign cap        = (state == S_READ) && !rxf_n_in;
    assign pop        = valid_out && ready_in;
    assign free       = CW'(FIFO_DEPTH) - count;
    // Same-edge pop is deliberately not credited, so the exit decision can never overflow.
    assign free_after = free - CW'(cap);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= S_IDLE;
            oe_n_out   <= 1'b1;
            rd_n_out   <= 1'b1;
            bus_rd_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rxf_n_in && (free >= CW'(MIN_FREE))) begin
                        state      <= S_OE;
                        oe_n_out   <= 1'b0;
                        rd_n_out   <= 1'b1;
                        bus_rd_out <= 1'b1;
                    end
                end
                S_OE: begin
                    state      <= S_READ;
                    oe_n_out   <= 1'b0;
                    rd_n_out   <= 1'b0;
                    bus_rd_out <= 1'b1;
                end
                S_READ: begin
                    if (rxf_n_in || (free_after == '0)) begin
                        state      <= S_TURN;
                        oe_n_out   <= 1'b1;
                        rd_n_out   <= 1'b1;
                        bus_rd_out <= 1'b1;
                    end
                end
                S_TURN: begin
                    state      <= S_IDLE;
                    oe_n_out   <= 1'b1;
                    rd_n_out   <= 1'b1;
                    bus_rd_out <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    oe_n_out   <= 1'b1;
                    rd_n_out   <= 1'b1;
                    bus_rd_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            word_cnt_out <= '0;
        end else if (cap) begin
            word_cnt_out <= word_cnt_out + CNT_W'(1);
        end
    end

    rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (cap),
        .wdata     ({be_in, data_in}),
        .pop       (pop),
        .rdata     (head),
        .count     (count),
        .not_empty (valid_out)
    );

    assign data_out = head[DATA_W-1:0];
    assign be_out   = head[DATA_W +: BE_W];

endmodule

// File: tb/tb_ft_rx_reader.sv
// Directed bench for ft_rx_reader: FT601 source model, in-order scoreboard and cycle tables.
module tb_ft_rx_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxf_n = 1'b1;
    logic        ready = 1'b0;
    logic [31:0] data = '0;
    logic [3:0]  be = '0;

    logic        oe_n, rd_n, bus_rd, valid;
    logic [31:0] dout, cnt;
    logic [3:0]  bout;
    logic        oe_n_w, rd_n_w, bus_rd_w, valid_w;
    logic [31:0] dout_w;
    logic [3:0]  bout_w, cnt_w;

    always #5 clk = ~clk;

    ft_rx_reader #(
        .DATA_W (32), .BE_W (4), .FIFO_DEPTH (16), .CNT_W (32)
    ) dut (
        .clk_in (clk), .rst_in (rst_n), .rxf_n_in (rxf_n), .data_in (data), .be_in (be),
        .oe_n_out (oe_n), .rd_n_out (rd_n), .bus_rd_out (bus_rd), .data_out (dout),
        .be_out (bout), .valid_out (valid), .ready_in (ready), .word_cnt_out (cnt)
    );

    // Narrow-counter copy on the same stimulus, to exercise the count wrap quickly.
    ft_rx_reader #(
        .DATA_W (32), .BE_W (4), .FIFO_DEPTH (16), .CNT_W (4)
    ) dut_w (
        .clk_in (clk), .rst_in (rst_n), .rxf_n_in (rxf_n), .data_in (data), .be_in (be),
        .oe_n_out (oe_n_w), .rd_n_out (rd_n_w), .bus_rd_out (bus_rd_w), .data_out (dout_w),
        .be_out (bout_w), .valid_out (valid_w), .ready_in (ready), .word_cnt_out (cnt_w)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned ptr = 0;
    int unsigned avail = 0;
    int unsigned exp_idx = 0;
    int unsigned cap_cnt = 0;
    bit          pulse = 1'b0;
    logic        last_rd_n = 1'b1;

    typedef struct {
        int unsigned add;
        bit          pls;
        bit          rdy;
        bit          oe_n;
        bit          rd_n;
        bit          bus;
        bit          vld;
        int unsigned cnt;
    } row_t;

    row_t rows [19];

    function automatic logic [31:0] word_data(input int unsigned w);
        return w + 32'd1;
    endfunction

    function automatic logic [3:0] word_be(input int unsigned w);
        return 4'(~w);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        if (pulse) begin
            rxf_n = 1'b0;
            pulse = 1'b0;
        end else begin
            rxf_n = (ptr >= avail);
        end
        data = word_data(ptr);
        be   = word_be(ptr);
    endtask

    // One clock: score the pop about to happen, advance the source on a capture, re-drive.
    task automatic tick();
        if (valid && ready) begin
            check("pop_data", dout, word_data(exp_idx));
            check("pop_be", 32'(bout), 32'(word_be(exp_idx)));
            exp_idx++;
        end
        last_rd_n = rd_n;
        @(negedge clk);
        if (!last_rd_n && !rxf_n) begin
            ptr++;
            cap_cnt++;
        end
        check("word_cnt", cnt, cap_cnt);
        check("word_cnt_w", 32'(cnt_w), cap_cnt & 32'hF);
        drive();
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ready = rows[i].rdy;
            avail += rows[i].add;
            if (rows[i].pls) pulse = 1'b1;
            drive();
            tick();
            check($sformatf("row%0d_oe_n", i), 32'(oe_n), 32'(rows[i].oe_n));
            check($sformatf("row%0d_rd_n", i), 32'(rd_n), 32'(rows[i].rd_n));
            check($sformatf("row%0d_bus_rd", i), 32'(bus_rd), 32'(rows[i].bus));
            check($sformatf("row%0d_valid", i), 32'(valid), 32'(rows[i].vld));
            check($sformatf("row%0d_cnt", i), cnt, rows[i].cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int unsigned start;
        bit          done;

        // idle with RXF_N high
        for (int i = 0; i < 4; i++) rows[i] = '{0, 0, 0, 1, 1, 0, 0, 0};
        // 5-word burst with consumer ready
        rows[4]  = '{5, 0, 1, 0, 1, 1, 0, 0};
        rows[5]  = '{0, 0, 1, 0, 0, 1, 0, 0};
        rows[6]  = '{0, 0, 1, 0, 0, 1, 1, 1};
        rows[7]  = '{0, 0, 1, 0, 0, 1, 1, 2};
        rows[8]  = '{0, 0, 1, 0, 0, 1, 1, 3};
        rows[9]  = '{0, 0, 1, 0, 0, 1, 1, 4};
        rows[10] = '{0, 0, 1, 0, 0, 1, 1, 5};
        rows[11] = '{0, 0, 1, 1, 1, 1, 0, 5};
        rows[12] = '{0, 0, 1, 1, 1, 0, 0, 5};
        rows[13] = '{0, 0, 1, 1, 1, 0, 0, 5};
        // one-cycle RXF_N pulse: OE, READ with no capture, TURN, IDLE
        rows[14] = '{0, 1, 1, 0, 1, 1, 0, 35};
        rows[15] = '{0, 0, 1, 0, 0, 1, 0, 35};
        rows[16] = '{0, 0, 1, 1, 1, 1, 0, 35};
        rows[17] = '{0, 0, 1, 1, 1, 0, 0, 35};
        rows[18] = '{0, 0, 1, 1, 1, 0, 0, 35};

        drive();
        repeat (3) @(negedge clk);
        check("rst_oe_n", 32'(oe_n), 32'd1);
        check("rst_rd_n", 32'(rd_n), 32'd1);
        check("rst_bus_rd", 32'(bus_rd), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", dout, 32'd0);
        check("rst_be", 32'(bout), 32'd0);
        check("rst_cnt", cnt, 32'd0);
        rst_n = 1'b1;

        apply_rows(0, 13);

        // Fill: consumer stalled, source always has data.
        ready = 1'b0;
        avail += 30;
        start = ptr;
        drive();
        repeat (25) tick();
        check("fill_captures", ptr - start, 32'd16);
        check("fill_oe_n", 32'(oe_n), 32'd1);
        check("fill_rd_n", 32'(rd_n), 32'd1);
        check("fill_bus_rd", 32'(bus_rd), 32'd0);
        check("fill_valid", 32'(valid), 32'd1);
        check("fill_cnt", cnt, 32'd21);
        check("fill_cnt_w_wrap", 32'(cnt_w), 32'd5);

        // Drain and let the remaining words stream through.
        ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            tick();
            done = (ptr == avail) && !valid && oe_n && !bus_rd;
        end
        check("drain_done", 32'(done), 32'd1);
        check("drain_all_popped", exp_idx, ptr);
        check("drain_cnt", cnt, 32'd35);

        apply_rows(14, 18);

        // Reset in the middle of a burst after three captures.
        ready = 1'b0;
        avail += 10;
        start = ptr;
        drive();
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            done = (ptr - start == 3);
        end
        check("midburst_reached", 32'(done), 32'd1);
        check("midburst_rd_n_low", 32'(rd_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_oe_n", 32'(oe_n), 32'd1);
        check("arst_rd_n", 32'(rd_n), 32'd1);
        check("arst_bus_rd", 32'(bus_rd), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_cnt", cnt, 32'd0);
        check("arst_data", dout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        avail = ptr;
        exp_idx = ptr;
        cap_cnt = 0;
        drive();
        repeat (3) tick();
        check("post_rst_oe_n", 32'(oe_n), 32'd1);
        check("post_rst_valid", 32'(valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ft_rx_reader.md
Name: ft_rx_reader

Overview:
- Master-side reader for the FT601 245-synchronous FIFO interface: drives OE_N/RD_N, samples DATA/BE while RXF_N is low, and buffers received words.
- Presents buffered words to FPGA logic as a valid/ready stream.
- Runs in the CLK_FTDI (100 MHz) domain alongside data_gateway; top-level tristate control uses bus_rd_out to release DATA/BE while reading.

Parameters:
- DATA_W, 32, FT601 data bus width.
- BE_W, 4, byte-enable width.
- FIFO_DEPTH, 16, receive buffer entries (power of two, >= 4).
- CNT_W, 32, width of the received-word counter.

Ports:
- clk_in  input  1  CLK_FTDI, 100 MHz; all logic on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rxf_n_in  input  1  FT601 RXF_N; low = data available.
- data_in  input  DATA_W  FT601 DATA, sampled while reading.
- be_in  input  BE_W  FT601 BE, sampled while reading.
- oe_n_out  output  1  FT601 OE_N, registered.
- rd_n_out  output  1  FT601 RD_N, registered.
- bus_rd_out  output  1  high while OE_N is low or in turnaround; top must tristate DATA/BE.
- data_out  output  DATA_W  head-of-buffer data (show-ahead).
- be_out  output  BE_W  head-of-buffer byte enables.
- valid_out  output  1  buffer not empty.
- ready_in  input  1  consumer accepts the word when valid_out && ready_in.
- word_cnt_out  output  CNT_W  total words captured, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): state IDLE, oe_n_out=1, rd_n_out=1, bus_rd_out=0, buffer empty, valid_out=0, data_out=0, be_out=0, word_cnt_out=0.
- FSM states: IDLE, OE, READ, TURN. Outputs are registered and decoded from the state.
  - IDLE: oe_n=1, rd_n=1, bus_rd=0. Go to OE when rxf_n_in==0 and free >= 2.
  - OE: oe_n=0, rd_n=1, bus_rd=1. Go to READ unconditionally after one cycle.
  - READ: oe_n=0, rd_n=0, bus_rd=1.
  - TURN: oe_n=1, rd_n=1, bus_rd=1. Go to IDLE after one cycle (bus turnaround).
- Capture rule: at each rising edge with state==READ and rxf_n_in==0, push {be_in, data_in} into the buffer and increment word_cnt_out. No capture in any other state.
- READ exit: go to TURN at an edge where rxf_n_in==1, or where (free - cap)==0. Here free is the count before this edge's pop and cap is 1 if this edge captures.
- A simultaneous pop is not credited to free for the exit decision; this conservative rule guarantees no overflow.
- Push and pop on the same edge are both performed; the count is unchanged.
- rxf_n_in rising in OE: still go to READ, no capture, then exit to TURN on the next edge.
- Minimum read burst overhead: 1 OE cycle + 1 TURN cycle. Re-entry from TURN goes through IDLE, so at least 3 cycles between bursts.
- Buffer is show-ahead: data_out/be_out are valid in the cycle valid_out rises. Latency from capture edge to valid_out is 1 edge (registered count).
- Pop when valid_out && ready_in. ready_in with an empty buffer is ignored.
- Reset mid-burst: OE_N/RD_N go high immediately (async); buffered data is discarded.
- word_cnt_out wraps 2^CNT_W-1 -> 0 without flag.

Decomposition:
- Package ft_rx_pkg holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_OE=2'd1, ST_READ=2'd2, ST_TURN=2'd3
  - default widths DATA_W=32, BE_W=4
  - MIN_FREE=2
- Sub-module rx_fifo: single-clock show-ahead FIFO, width DATA_W+BE_W, depth FIFO_DEPTH. It exposes a count output so the FSM can compute free.

Test Plan:
- Reset then rxf_n_in=1 forever -> oe_n_out=rd_n_out=1, valid_out=0, word_cnt_out=0.
- rxf_n_in low for 5 words (data 0x00000001..5, be 0xF), ready_in=1:
  - oe_n falls 1 cycle after rxf low; rd_n falls 1 cycle later.
  - 5 words output in order; word_cnt_out=5; TURN cycle observed before IDLE.
- ready_in=0, rxf_n_in held low with an incrementing pattern, FIFO_DEPTH=16:
  - exactly 16 words captured, rd_n_out returns high, no overflow.
  - Then ready_in=1 drains 16 words; reading resumes, sequence continuous with no gaps or duplicates.
- rxf_n_in pulses low for 1 cycle in IDLE, high by the OE edge -> OE then READ with zero captures, TURN, IDLE; word_cnt_out unchanged.
- Async rst_in low during READ after 3 captures -> oe_n/rd_n high the same cycle, valid_out=0, word_cnt_out=0.
- Preload word_cnt_out to 0xFFFFFFFF via a 2^32-1 capture stream (or CNT_W=4 build with 16 words) -> next capture wraps the count to 0.
